// File: rtl/cnt_arb_pkg.sv
// Shared types and default constants for the cnt_step_arbiter slice.
// Optional build macro used by the top: CNT_CLEAR_EN.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_MOD  = 5;
    localparam int DEF_CW   = 3;
    localparam int DEF_SW   = 3;
    localparam int DEF_IW   = 2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cnt_step_arbiter_mod_updown_cnt.sv
// Modulo-MOD up/down step counter; advances one position per cycle while en is high.
module mod_updown_cnt
    import cnt_arb_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int CW  = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          up,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap explicitly at both ends so non-power-of-two moduli stay in 0..MOD-1.
    always_comb begin
        cnt_d = cnt_q;
        if (up == DIR_UP) begin
            cnt_d = (cnt_q == CW'(MOD - 1)) ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = (cnt_q == '0) ? CW'(MOD - 1) : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cnt_step_arbiter.sv
// Round-robin arbitrated access to one shared modulo up/down step counter.
// Optional macro CNT_CLEAR_EN adds a clr_req input that zeroes the count while idle.
module cnt_step_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int MOD  = DEF_MOD,
    parameter int CW   = DEF_CW,
    parameter int SW   = DEF_SW,
    parameter int IW   = DEF_IW
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef CNT_CLEAR_EN
    input  logic                 clr_req,
`endif
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_dir,
    input  logic [NREQ*SW-1:0]   req_steps,
    output logic [NREQ-1:0]      req_ready,
    output logic                 busy,
    output logic [IW-1:0]        owner,
    output logic [CW-1:0]        cnt,
    output logic                 done,
    output logic [IW-1:0]        done_id
);

    state_t          state_q;
    logic [SW-1:0]   remaining_q;
    logic            dir_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   lastWinner_q;
    logic            busy_q;
    logic            done_q;
    logic [IW-1:0]   doneId_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   winner;
    logic            anyValid;
    logic            clrHit;
    logic            accept;
    logic            dirSel;
    logic [SW-1:0]   stepsSel;
    logic            cntRstN;

    // Rotating priority: the first valid requester after the last winner wins.
    always_comb begin : arbSearch
        int              idx;
        logic [NREQ-1:0] sel;
        grant    = '0;
        winner   = '0;
        anyValid = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(lastWinner_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = NREQ'(1) << idx;
            if (!anyValid && (|(req_valid & sel))) begin
                anyValid = 1'b1;
                winner   = IW'(idx);
                grant    = sel;
            end
        end
    end

`ifdef CNT_CLEAR_EN
    assign clrHit = (state_q == IDLE) && clr_req;
`else
    assign clrHit = 1'b0;
`endif

    assign accept    = reset_n && (state_q == IDLE) && anyValid && !clrHit;
    assign req_ready = accept ? grant : '0;
    assign dirSel    = |(req_dir & grant);
    assign stepsSel  = SW'(req_steps >> (int'(winner) * SW));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            dir_q        <= DIR_DN;
            owner_q      <= '0;
            lastWinner_q <= IW'(NREQ - 1);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            doneId_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        dir_q        <= dirSel;
                        remaining_q  <= stepsSel;
                        owner_q      <= winner;
                        lastWinner_q <= winner;
                        busy_q       <= 1'b1;
                        if (stepsSel != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            doneId_q <= winner;
                        end
                    end
                end
                RUN: begin
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == SW'(1)) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        doneId_q <= owner_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // An idle clear is just a synchronous reset of the counter alone.
    assign cntRstN = reset_n && !clrHit;

    mod_updown_cnt #(
        .MOD (MOD),
        .CW  (CW)
    ) u_cnt (
        .clk     (clk),
        .reset_n (cntRstN),
        .en      (state_q == RUN),
        .up      (dir_q),
        .cnt     (cnt)
    );

    assign busy    = busy_q;
    assign owner   = owner_q;
    assign done    = done_q;
    assign done_id = doneId_q;

endmodule
